// File: rtl/mmio_store_port.sv
// Memory-mapped output FIFO on the core data port: stores to DATA_ADDR queue bytes for a valid/ready consumer.
// Optional MMIO_STAT_EN decodes STAT_ADDR for status reads and the overflow-clear write.
module mmio_store_port #(
  parameter logic [7:0] DATA_ADDR = 8'hFF,
  parameter logic [7:0] STAT_ADDR = 8'hFE,
  parameter int         DEPTH     = 4,
  parameter int         PTR_W     = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rw_addr,
  input  logic [7:0] w,
  input  logic       w_en,
  output logic [7:0] r,
  output logic       hit,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       full,
  output logic       overflow
);

`ifdef MMIO_STAT_EN
  localparam bit STAT_EN = 1'b1;
`else
  localparam bit STAT_EN = 1'b0;
`endif

  localparam logic [PTR_W:0] DEPTH_C = (PTR_W + 1)'(DEPTH);

  logic [7:0]       mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W:0]   count;

  logic empty;
  logic data_sel;
  logic stat_sel;
  logic push_req;
  logic push;
  logic pop;
  logic drop;
  logic ovf_clr;

  assign empty    = (count == '0);
  assign full     = (count == DEPTH_C);
  assign data_sel = (rw_addr == DATA_ADDR);
  assign stat_sel = STAT_EN && (rw_addr == STAT_ADDR);

  // A full FIFO still accepts a store when the head leaves on the same edge.
  assign pop      = out_valid && out_ready;
  assign push_req = w_en && data_sel;
  assign push     = push_req && (!full || pop);
  assign drop     = push_req && full && !pop;
  assign ovf_clr  = w_en && stat_sel && w[7];

  assign out_valid = !empty;
  assign out_data  = empty ? 8'h00 : mem[rd_ptr];
  assign hit       = data_sel || stat_sel;

  always_comb begin
    // NOTE: default first so every path assigns r and no latch is inferred.
    r = 8'h00;
    if (data_sel)
      r = out_data;
    else if (stat_sel)
      r = {overflow, full, empty, 5'(count)};
  end

  // NOTE: the storage array has no reset; empty masks stale contents, and leaving it out keeps it a plain RAM.
  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= w;
  end

  // NOTE: non-blocking assignments so every register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)
        count <= count + 1'b1;
      else if (pop && !push)
        count <= count - 1'b1;
      // A dropped store wins over a same-cycle clear.
      if (drop)
        overflow <= 1'b1;
      else if (ovf_clr)
        overflow <= 1'b0;
    end
  end

endmodule
